// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC-3 memory/IO interface stage:
// IO address map, FSM states and KBSR bit positions.
package lc3_mem_pkg;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  localparam int KBSR_RDY_BIT = 15;
  localparam int KBSR_IE_BIT  = 14;

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    DONE
  } state_e;

  function automatic logic is_io(input logic [15:0] a);
    return (a == KBSR_ADDR) || (a == KBDR_ADDR) ||
           (a == DSR_ADDR)  || (a == DDR_ADDR);
  endfunction

endpackage

// File: rtl/lc3_io_regs.sv
// Keyboard/display device registers (KBSR, KBDR, DSR, DDR)
// with read mux and single-cycle register access port.
module lc3_io_regs
  import lc3_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        acc_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  wbyte_i,
  input  logic        wie_i,
  output logic [15:0] rdata_o,
  input  logic [7:0]  kb_data_i,
  input  logic        kb_valid_i,
  input  logic        disp_ack_i,
  output logic [7:0]  ddr_data_o,
  output logic        ddr_valid_o,
  output logic        kb_irq_o
);

  logic       kb_rdy_q, kb_rdy_d;
  logic       kb_ie_q, kb_ie_d;
  logic [7:0] kb_chr_q, kb_chr_d;
  logic       dsr_rdy_q, dsr_rdy_d;
  logic [7:0] ddr_q, ddr_d;
  logic       dv_q, dv_d;

  logic sel_kbsr, sel_kbdr, sel_dsr, sel_ddr;
  logic kbdr_rd, kbsr_wr, ddr_wr;

  assign sel_kbsr = addr_i == KBSR_ADDR;
  assign sel_kbdr = addr_i == KBDR_ADDR;
  assign sel_dsr  = addr_i == DSR_ADDR;
  assign sel_ddr  = addr_i == DDR_ADDR;

  assign kbdr_rd = acc_i && !we_i && sel_kbdr;
  assign kbsr_wr = acc_i && we_i && sel_kbsr;
  assign ddr_wr  = acc_i && we_i && sel_ddr;

  always_comb begin
    rdata_o = '0;
    unique case (1'b1)
      sel_kbsr: begin
        rdata_o[KBSR_RDY_BIT] = kb_rdy_q;
        rdata_o[KBSR_IE_BIT]  = kb_ie_q;
      end
      sel_kbdr: rdata_o = {8'h00, kb_chr_q};
      sel_dsr:  rdata_o = {dsr_rdy_q, 15'h0000};
      default:  rdata_o = '0;
    endcase
  end

  always_comb begin
    kb_rdy_d  = kb_rdy_q;
    kb_ie_d   = kb_ie_q;
    kb_chr_d  = kb_chr_q;
    dsr_rdy_d = dsr_rdy_q;
    ddr_d     = ddr_q;
    dv_d      = 1'b0;
    // A new key arriving with a KBDR read refills the now-empty slot
    if (kb_valid_i && (!kb_rdy_q || kbdr_rd)) begin
      kb_chr_d = kb_data_i;
      kb_rdy_d = 1'b1;
    end else if (kbdr_rd) begin
      kb_rdy_d = 1'b0;
    end
    if (kbsr_wr) kb_ie_d = wie_i;
    if (disp_ack_i) dsr_rdy_d = 1'b1;
    if (ddr_wr && dsr_rdy_q) begin
      ddr_d     = wbyte_i;
      dv_d      = 1'b1;
      dsr_rdy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kb_rdy_q  <= 1'b0;
      kb_ie_q   <= 1'b0;
      kb_chr_q  <= '0;
      dsr_rdy_q <= 1'b1;
      ddr_q     <= '0;
      dv_q      <= 1'b0;
    end else begin
      kb_rdy_q  <= kb_rdy_d;
      kb_ie_q   <= kb_ie_d;
      kb_chr_q  <= kb_chr_d;
      dsr_rdy_q <= dsr_rdy_d;
      ddr_q     <= ddr_d;
      dv_q      <= dv_d;
    end
  end

  assign ddr_data_o  = ddr_q;
  assign ddr_valid_o = dv_q;
  assign kb_irq_o    = kb_rdy_q && kb_ie_q;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory/IO interface stage: MAR/MDR, IO decode and
// multi-cycle memory sequencing with ready (r) handshake.
module lc3_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int DATASIZE = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] bus_in,
  input  logic                ld_mar,
  input  logic                ld_mdr,
  input  logic                mio_en,
  input  logic                r_w,
  output logic [DATASIZE-1:0] mar_q,
  output logic [DATASIZE-1:0] mdr_q,
  output logic                r,
  output logic                bus_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATASIZE-1:0] mem_addr,
  output logic [DATASIZE-1:0] mem_wdata,
  input  logic [DATASIZE-1:0] mem_rdata,
  input  logic                mem_ack,
  input  logic [7:0]          kb_data,
  input  logic                kb_valid,
  output logic [7:0]          ddr_data,
  output logic                ddr_valid,
  input  logic                disp_ack,
  output logic                kb_irq
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  state_e              state_q, state_d;
  logic [DATASIZE-1:0] mar_d, mdr_d;
  logic [DATASIZE-1:0] addr_q, addr_d;
  logic [DATASIZE-1:0] wdat_q, wdat_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                io_hit, io_acc;
  logic [15:0]         io_rdata;

  assign io_hit = is_io(mar_q);
  assign io_acc = (state_q == IDLE) && mio_en && io_hit;

  lc3_io_regs u_io (
    .clk         (clk),
    .rst_n       (rst_n),
    .acc_i       (io_acc),
    .we_i        (r_w),
    .addr_i      (mar_q),
    .wbyte_i     (mdr_q[7:0]),
    .wie_i       (mdr_q[KBSR_IE_BIT]),
    .rdata_o     (io_rdata),
    .kb_data_i   (kb_data),
    .kb_valid_i  (kb_valid),
    .disp_ack_i  (disp_ack),
    .ddr_data_o  (ddr_data),
    .ddr_valid_o (ddr_valid),
    .kb_irq_o    (kb_irq)
  );

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    req_d   = req_q;
    we_d    = we_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (ld_mar) mar_d = bus_in;
        if (ld_mdr && !mio_en) mdr_d = bus_in;
        if (mio_en && io_hit) begin
          if (!r_w) mdr_d = io_rdata;
          state_d = DONE;
        end else if (mio_en) begin
          addr_d  = mar_q;
          wdat_d  = mdr_q;
          we_d    = r_w;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        // ack wins over a timeout landing on the same cycle
        if (mem_ack) begin
          if (!we_q) mdr_d = mem_rdata;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CW'(WAIT_MAX - 1)) begin
          if (!we_q) mdr_d = '0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign r         = state_q == DONE;
  assign bus_err   = (state_q == DONE) && err_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdat_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed + randomized bench for lc3_mem_ctrl with a
// transaction-level memory/IO reference model.
module tb_lc3_mem_ctrl;

  localparam int WMAX = 15;
  localparam logic [15:0] A_KBSR = 16'hFE00;
  localparam logic [15:0] A_KBDR = 16'hFE02;
  localparam logic [15:0] A_DSR  = 16'hFE04;
  localparam logic [15:0] A_DDR  = 16'hFE06;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bus_in;
  logic        ld_mar, ld_mdr, mio_en, r_w;
  logic [15:0] mar_q, mdr_q;
  logic        r, bus_err, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [7:0]  kb_data;
  logic        kb_valid;
  logic [7:0]  ddr_data;
  logic        ddr_valid, disp_ack, kb_irq;

  int checks = 0;
  int errors = 0;
  logic [15:0] mem_m [logic [15:0]];

  lc3_mem_ctrl #(.DATASIZE(16), .WAIT_MAX(WMAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_in    (bus_in),
    .ld_mar    (ld_mar),
    .ld_mdr    (ld_mdr),
    .mio_en    (mio_en),
    .r_w       (r_w),
    .mar_q     (mar_q),
    .mdr_q     (mdr_q),
    .r         (r),
    .bus_err   (bus_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .kb_data   (kb_data),
    .kb_valid  (kb_valid),
    .ddr_data  (ddr_data),
    .ddr_valid (ddr_valid),
    .disp_ack  (disp_ack),
    .kb_irq    (kb_irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_mar(input logic [15:0] v);
    bus_in = v; ld_mar = 1'b1;
    tick();
    ld_mar = 1'b0;
  endtask

  task automatic load_mdr(input logic [15:0] v);
    bus_in = v; ld_mdr = 1'b1;
    tick();
    ld_mdr = 1'b0;
  endtask

  task automatic kb_push(input logic [7:0] d);
    kb_valid = 1'b1; kb_data = d;
    tick();
    kb_valid = 1'b0;
  endtask

  task automatic io_access(input logic [15:0] a, input logic rw,
                           input logic kbv, input logic [7:0] kbd,
                           output logic dv);
    load_mar(a);
    mio_en = 1'b1; r_w = rw; kb_valid = kbv; kb_data = kbd;
    tick();
    mio_en = 1'b0; r_w = 1'b0; kb_valid = 1'b0;
    chk("io_r", r, 1);
    chk("io_err", bus_err, 0);
    dv = ddr_valid;
    tick();
    chk("io_r_once", r, 0);
  endtask

  task automatic io_rd(input string tag, input logic [15:0] a,
                       input logic [15:0] exp);
    logic dv;
    io_access(a, 1'b0, 1'b0, 8'h00, dv);
    chk(tag, mdr_q, exp);
  endtask

  task automatic mem_access(input logic [15:0] a, input logic [15:0] wd,
                            input logic rw, input int delay,
                            input logic [15:0] rdv, input bit noise);
    logic [15:0] new_mar, mar_exp, mdr_exp;
    int n, exp_n;
    bit got_r;
    logic err;
    bit ok;
    load_mar(a);
    load_mdr(wd);
    new_mar = 16'($urandom);
    bus_in = new_mar; ld_mar = noise;
    mio_en = 1'b1; r_w = rw;
    tick();
    ld_mar = 1'b0; mio_en = 1'b0; r_w = 1'b0;
    mar_exp = noise ? new_mar : a;
    ok = delay <= WMAX;
    exp_n = ok ? delay : WMAX;
    mdr_exp = rw ? wd : (ok ? rdv : 16'h0000);
    n = 0; got_r = 0; err = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (r) begin
        got_r = 1; err = bus_err;
        break;
      end
      if (mem_req) begin
        n++;
        if (n == 1) begin
          chk("mem_addr", mem_addr, a);
          chk("mem_we", mem_we, rw);
          chk("mem_wdata", mem_wdata, wd);
        end
      end
      mem_ack = mem_req && (n == delay);
      mem_rdata = rdv;
      ld_mar = noise; ld_mdr = noise; mio_en = noise;
      bus_in = 16'($urandom);
      tick();
      mem_ack = 1'b0;
    end
    ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0;
    chk("mem_r_seen", got_r, 1);
    chk("mem_req_cycles", n, exp_n);
    chk("mem_bus_err", err, !ok);
    chk("mem_mdr", mdr_q, mdr_exp);
    chk("mem_mar", mar_q, mar_exp);
    if (ok && rw) mem_m[a] = wd;
    if (ok && !rw) mem_m[a] = rdv;
    tick();
    chk("mem_r_once", r, 0);
    chk("mem_req_idle", mem_req, 0);
  endtask

  initial begin
    logic dv;
    logic [15:0] ra, rd, wd;
    logic rw;
    int dly;
    rst_n = 1'b0; bus_in = '0; ld_mar = 0; ld_mdr = 0;
    mio_en = 0; r_w = 0; mem_rdata = '0; mem_ack = 0;
    kb_data = '0; kb_valid = 0; disp_ack = 0;
    tick(); tick();
    chk("rst_mar", mar_q, 0);
    chk("rst_mdr", mdr_q, 0);
    chk("rst_r", r, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_dv", ddr_valid, 0);
    chk("rst_dd", ddr_data, 0);
    chk("rst_irq", kb_irq, 0);
    rst_n = 1'b1;
    tick();

    mem_access(16'h3000, 16'h0000, 1'b0, 3, 16'h1234, 0);
    mem_access(16'h4000, 16'hBEEF, 1'b1, 4, 16'h0000, 0);
    mem_access(16'h5000, 16'h7777, 1'b0, 99, 16'hAAAA, 0);
    mem_access(16'h6000, 16'h1357, 1'b1, 99, 16'h0000, 1);
    mem_access(16'h3002, 16'h2222, 1'b0, WMAX, 16'h9999, 1);

    io_rd("dsr_init", A_DSR, 16'h8000);
    kb_push(8'h41);
    io_rd("kbsr_rdy", A_KBSR, 16'h8000);
    io_access(A_KBDR, 1'b0, 1'b1, 8'h42, dv);
    chk("kbdr_old", mdr_q, 16'h0041);
    io_rd("kbsr_refill", A_KBSR, 16'h8000);
    io_rd("kbdr_new", A_KBDR, 16'h0042);
    io_rd("kbsr_clr", A_KBSR, 16'h0000);
    kb_push(8'h61);
    kb_push(8'h62);
    io_rd("kbdr_drop", A_KBDR, 16'h0061);
    load_mdr(16'h4000);
    io_access(A_KBSR, 1'b1, 1'b0, 8'h00, dv);
    chk("irq_noready", kb_irq, 0);
    kb_push(8'h63);
    chk("irq_set", kb_irq, 1);
    io_rd("kbsr_ie", A_KBSR, 16'hC000);
    load_mdr(16'h0000);
    io_access(A_KBSR, 1'b1, 1'b0, 8'h00, dv);
    chk("irq_off", kb_irq, 0);

    load_mdr(16'h0058);
    io_access(A_DDR, 1'b1, 1'b0, 8'h00, dv);
    chk("ddr_strobe", dv, 1);
    chk("ddr_data", ddr_data, 8'h58);
    chk("ddr_pulse", ddr_valid, 0);
    io_rd("dsr_busy", A_DSR, 16'h0000);
    load_mdr(16'h0059);
    io_access(A_DDR, 1'b1, 1'b0, 8'h00, dv);
    chk("ddr_nostrobe", dv, 0);
    chk("ddr_kept", ddr_data, 8'h58);
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
    io_rd("dsr_ack", A_DSR, 16'h8000);
    load_mdr(16'h005A);
    io_access(A_DDR, 1'b1, 1'b0, 8'h00, dv);
    chk("ddr_strobe2", dv, 1);
    chk("ddr_data2", ddr_data, 8'h5A);

    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom);
      if (ra inside {A_KBSR, A_KBDR, A_DSR, A_DDR}) ra = ra ^ 16'h8000;
      rw = 1'($urandom);
      dly = int'($urandom_range(1, 18));
      wd = 16'($urandom);
      rd = mem_m.exists(ra) ? mem_m[ra] : 16'($urandom);
      mem_access(ra, wd, rw, dly, rd, 1'($urandom));
    end

    load_mar(16'h3000);
    mio_en = 1'b1; r_w = 1'b0;
    tick();
    mio_en = 1'b0;
    tick(); tick();
    chk("mid_req", mem_req, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_r", r, 0);
    chk("mid_rst_mar", mar_q, 0);
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_ack_r", r, 0);
      chk("late_ack_mdr", mdr_q, 0);
      tick();
    end
    load_mar(16'h1111);
    chk("mid_rst_idle", mar_q, 16'h1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_mem_ctrl.md
Name: lc3_mem_ctrl

Overview:
- Memory/IO interface stage of the LC-3 datapath. It owns MAR and MDR, decodes memory-mapped I/O addresses, and sequences multi-cycle memory accesses with a ready (R) handshake back to the control FSM.
- It feeds the write-data routing stage downstream, which steers MDR contents to the selected destination.

Parameters:
- DATASIZE, 16, data and address width.
- WAIT_MAX, 15, maximum cycles to wait for mem_ack before aborting with bus_err.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- bus_in  input  DATASIZE  datapath bus value.
- ld_mar  input  1  load MAR from bus_in.
- ld_mdr  input  1  load MDR from bus_in when mio_en=0.
- mio_en  input  1  start a memory/IO access at address MAR.
- r_w  input  1  1=write MDR to address, 0=read into MDR.
- mar_q  output  DATASIZE  MAR contents.
- mdr_q  output  DATASIZE  MDR contents.
- r  output  1  one-cycle pulse: access complete.
- bus_err  output  1  one-cycle pulse, coincident with r, on timeout.
- mem_req  output  1  memory request, held until ack.
- mem_we  output  1  write qualifier, valid with mem_req.
- mem_addr  output  DATASIZE  latched access address.
- mem_wdata  output  DATASIZE  latched write data.
- mem_rdata  input  DATASIZE  read data, valid with mem_ack.
- mem_ack  input  1  memory completion.
- kb_data  input  8  keyboard character.
- kb_valid  input  1  keyboard strobe.
- ddr_data  output  8  display character.
- ddr_valid  output  1  one-cycle display strobe.
- disp_ack  input  1  display has consumed the character.
- kb_irq  output  1  KBSR.ready & KBSR.ie.

Behaviour:
- Reset: MAR=0, MDR=0, state IDLE, r=0, bus_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ddr_valid=0, ddr_data=0, KBSR.ready=0, KBSR.ie=0, KBDR=0, DSR.ready=1, kb_irq=0.
- Reset asserted mid-access returns to IDLE immediately and drops mem_req the same edge. A late mem_ack is ignored.
- Address map: xFE00 KBSR, xFE02 KBDR, xFE04 DSR, xFE06 DDR. All other addresses are memory.
- IO register read formats:
  - KBSR = {ready, ie, 14'b0}.
  - KBDR = {8'b0, kb_char}.
  - DSR = {ready, 15'b0}.
- FSM states: IDLE, MEM_WAIT, DONE.
  - IDLE + mio_en, memory address: latch mem_addr=MAR, mem_wdata=MDR, mem_we=r_w. Assert mem_req next cycle and go to MEM_WAIT.
  - IDLE + mio_en, IO address: perform the register access and go to DONE. Latency is 1 cycle: r is high the cycle after mio_en.
  - MEM_WAIT + mem_ack: on read, MDR<=mem_rdata. Drop mem_req and go to DONE.
  - MEM_WAIT timeout: when the wait counter reaches WAIT_MAX without ack, drop mem_req and pulse bus_err. On read, MDR<=16'h0000. Go to DONE.
  - DONE: r=1 for exactly one cycle, then IDLE.
- Register loads:
  - ld_mar is honoured only in IDLE; outside IDLE it is ignored.
  - ld_mdr with mio_en=0 is honoured only in IDLE.
  - mio_en outside IDLE is ignored and does not queue.
  - ld_mar and mio_en in the same IDLE cycle: the access uses the old MAR.
- IO read of KBDR clears KBSR.ready in the completing cycle.
- Keyboard input:
  - kb_valid with ready=0: latch kb_char and set ready.
  - kb_valid with ready=1: dropped.
  - kb_valid in the same cycle as a KBDR read: the new char is latched, ready ends at 1, and MDR gets the old char.
- IO write to KBSR stores bit14 into ie. Other bits are ignored.
- IO write to DDR:
  - DSR.ready=1: ddr_data<=MDR[7:0], pulse ddr_valid, clear DSR.ready.
  - DSR.ready=0: write dropped, r still pulses.
- disp_ack sets DSR.ready.
- Writes to KBDR/DSR are ignored.

Decomposition:
- Package lc3_mem_pkg holds:
  - IO address constants (KBSR_ADDR, KBDR_ADDR, DSR_ADDR, DDR_ADDR).
  - FSM state enum (IDLE, MEM_WAIT, DONE).
  - KBSR bit-index constants.
- One sub-module, lc3_io_regs, holds KBSR/KBDR/DSR and the DDR strobe, with read mux and keyboard/display side. The FSM, MAR/MDR and timeout counter stay in lc3_mem_ctrl.

Test Plan:
- Memory read: MAR=x3000, mio_en r_w=0, mem_ack after 3 cycles with x1234 -> mem_req high 3 cycles, MDR=x1234, r pulses once on the cycle after ack.
- Memory write: MDR=xBEEF, MAR=x4000, r_w=1 -> mem_we=1, mem_addr=x4000, mem_wdata=xBEEF held until ack; MDR unchanged; r pulses once.
- Timeout: no mem_ack -> after WAIT_MAX=15 cycles mem_req drops, bus_err and r pulse together, MDR=x0000.
- Keyboard: kb_valid with x41 -> KBSR read=x8000; KBDR read=x0041 and KBSR.ready cleared. kb_valid x42 in the same cycle as that KBDR read -> MDR=x0041, KBSR.ready=1, next KBDR read=x0042.
- Display: write DDR with MDR=x0058 -> ddr_valid pulse, ddr_data=x58, DSR read=x0000. Second DDR write before disp_ack -> no strobe. After disp_ack -> DSR=x8000.
- Reset mid-MEM_WAIT: rst_n low one cycle -> mem_req=0, state IDLE, r=0. Late mem_ack produces no r.
